fifo_sync_prog: RTL and testbench

Parametrised synchronous FIFO, next generation of the team's 16x8 FIFO DUT: arbitrary width and depth (non-power-of-two allowed), programmable almost-full/almost-empty levels, an occupancy count output, and per-cycle status pulses for write-acknowledge, overflow and underflow. It is the storage element between a producer and a consumer in one clock domain. It is also the next DUT for the constrained-random transaction environment.

---
 rtl/fifo_sync_prog.sv | 89 ++++++++
 tb/tb_fifo_sync_prog.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO: any width/depth, programmable almost-full/empty levels, occupancy count and per-cycle status pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered on each accepted read.
module fifo_sync_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_wr_en,
  input  logic                            i_rd_en,
  input  logic [FIFO_WIDTH-1:0]           i_data_in,
  output logic [FIFO_WIDTH-1:0]           o_data_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
  output logic                            o_full,
  output logic                            o_empty,
  output logic                            o_almostfull,
  output logic                            o_almostempty,
  output logic                            o_wr_ack,
  output logic                            o_overflow,
  output logic                            o_underflow
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);
  localparam logic [PW-1:0] P_LAST  = PW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_wr_ack, r_overflow, r_underflow;
  logic                  w_wr_acc, w_rd_acc;

  // Accept decisions use the pre-edge count, so a full FIFO still pops on a simultaneous read.
  assign w_wr_acc = i_wr_en && (r_count < C_DEPTH);
  assign w_rd_acc = i_rd_en && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= i_wr_en && !w_wr_acc;
      r_underflow <= i_rd_en && !w_rd_acc;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_wr_acc) r_mem[r_wr_ptr] <= i_data_in;
  end

`ifdef FIFO_FWFT_EN
  assign o_data_out = r_mem[r_rd_ptr];
`else
  logic [FIFO_WIDTH-1:0] r_data_out;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)      r_data_out <= '0;
    else if (w_rd_acc) r_data_out <= r_mem[r_rd_ptr];
  end

  assign o_data_out = r_data_out;
`endif

  assign o_count       = r_count;
  assign o_full        = (r_count == C_DEPTH);
  assign o_empty       = (r_count == '0);
  assign o_almostfull  = (r_count >= C_AF);
  assign o_almostempty = (r_count <= C_AE);
  assign o_wr_ack      = r_wr_ack;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;
endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: an 8-deep instance (AF=6, AE=2) and a 5-deep instance, checked against a queue model.
module tb_fifo_sync_prog;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       we, re;
  logic [1:0][15:0] din, dout;
  logic [3:0]       cnt_a;
  logic [2:0]       cnt_b;
  logic [1:0]       full, empty, af, ae, ack, ovf, udf;

  fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(we[0]), .i_rd_en(re[0]), .i_data_in(din[0]),
    .o_data_out(dout[0]), .o_count(cnt_a), .o_full(full[0]), .o_empty(empty[0]),
    .o_almostfull(af[0]), .o_almostempty(ae[0]), .o_wr_ack(ack[0]), .o_overflow(ovf[0]),
    .o_underflow(udf[0]));

  fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(we[1]), .i_rd_en(re[1]), .i_data_in(din[1]),
    .o_data_out(dout[1]), .o_count(cnt_b), .o_full(full[1]), .o_empty(empty[1]),
    .o_almostfull(af[1]), .o_almostempty(ae[1]), .o_wr_ack(ack[1]), .o_overflow(ovf[1]),
    .o_underflow(udf[1]));

  int tests = 0;
  int fails = 0;

  // Reference model: a queue per instance plus the last popped word and expected pulses.
  logic [15:0] qa[$], qb[$];
  logic [15:0] m_dout [2];
  bit          m_ack [2], m_ovf [2], m_udf [2];

  function automatic int msize(int s);  return s ? qb.size() : qa.size(); endfunction
  function automatic int mdepth(int s); return s ? 5 : 8; endfunction
  function automatic int maf(int s);    return s ? 4 : 6; endfunction
  function automatic int mae(int s);    return s ? 1 : 2; endfunction
  function automatic int obs_cnt(int s); return s ? int'(cnt_b) : int'(cnt_a); endfunction

  function automatic bit data_valid(int s);
`ifdef FIFO_FWFT_EN
    return msize(s) > 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [15:0] m_data(int s);
`ifdef FIFO_FWFT_EN
    return s ? qb[0] : qa[0];
`else
    return m_dout[s];
`endif
  endfunction

  task automatic model_clear();
    qa.delete();
    qb.delete();
    for (int k = 0; k < 2; k++) begin
      m_dout[k] = '0; m_ack[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
    end
  endtask

  // One clock with a request on instance s (the other idles); updates the model afterwards.
  task automatic cyc(int s, bit w, bit r, logic [15:0] d);
    int n;
    bit wa, ra;
    we = '0; re = '0; we[s] = w; re[s] = r; din[s] = d;
    n  = msize(s);
    wa = w && (n < mdepth(s));
    ra = r && (n > 0);
    @(posedge clk); #1;
    we = '0; re = '0;
    for (int k = 0; k < 2; k++) begin m_ack[k] = 0; m_ovf[k] = 0; m_udf[k] = 0; end
    if (ra) m_dout[s] = s ? qb.pop_front() : qa.pop_front();
    if (wa) begin
      if (s != 0) qb.push_back(d);
      else        qa.push_back(d);
    end
    m_ack[s] = wa; m_ovf[s] = w && !wa; m_udf[s] = r && !ra;
  endtask

  task automatic do_reset(bit w);
    rst_n = 1'b0; we = {w, w}; re = '0; din = '{16'hDEAD, 16'hBEEF};
    @(posedge clk); #1;
    rst_n = 1'b1; we = '0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    for (int s = 0; s < 2; s++) begin
      tests++; if (obs_cnt(s) != 0) begin fails++; $display("FAIL reset_count[%0d] got %0d exp 0", s, obs_cnt(s)); end
      tests++; if (empty[s] !== 1'b1 || full[s] !== 1'b0) begin fails++; $display("FAIL reset_flags[%0d] got empty=%b full=%b exp 1 0", s, empty[s], full[s]); end
      tests++; if (ae[s] !== 1'b1 || af[s] !== 1'b0) begin fails++; $display("FAIL reset_almost[%0d] got ae=%b af=%b exp 1 0", s, ae[s], af[s]); end
      tests++; if ({ack[s], ovf[s], udf[s]} !== 3'b000) begin fails++; $display("FAIL reset_pulses[%0d] got %b exp 000", s, {ack[s], ovf[s], udf[s]}); end
`ifndef FIFO_FWFT_EN
      tests++; if (dout[s] !== 16'h0) begin fails++; $display("FAIL reset_dout[%0d] got %h exp 0000", s, dout[s]); end
`endif
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 16'hA000 + 16'(i));
      tests++; if (ack[0] !== 1'b1) begin fails++; $display("FAIL fill_ack[%0d] got %b exp 1", i, ack[0]); end
    end
    tests++; if (full[0] !== 1'b1 || cnt_a !== 4'd8) begin fails++; $display("FAIL fill_full got full=%b cnt=%0d exp 1 8", full[0], cnt_a); end
    for (int i = 0; i < 8; i++) begin
`ifdef FIFO_FWFT_EN
      tests++; if (dout[0] !== 16'hA000 + 16'(i)) begin fails++; $display("FAIL drain_data[%0d] got %h exp %h", i, dout[0], 16'hA000 + 16'(i)); end
      cyc(0, 0, 1, 16'h0);
`else
      cyc(0, 0, 1, 16'h0);
      tests++; if (dout[0] !== 16'hA000 + 16'(i)) begin fails++; $display("FAIL drain_data[%0d] got %h exp %h", i, dout[0], 16'hA000 + 16'(i)); end
`endif
    end
    tests++; if (empty[0] !== 1'b1 || cnt_a !== 4'd0) begin fails++; $display("FAIL drain_empty got empty=%b cnt=%0d exp 1 0", empty[0], cnt_a); end
  endtask

  task automatic test_over_under();
    cyc(0, 0, 1, 16'h0);
    tests++; if (udf[0] !== 1'b1 || cnt_a !== 4'd0) begin fails++; $display("FAIL underflow got udf=%b cnt=%0d exp 1 0", udf[0], cnt_a); end
`ifndef FIFO_FWFT_EN
    tests++; if (dout[0] !== 16'hA007) begin fails++; $display("FAIL underflow_dout got %h exp a007", dout[0]); end
`endif
    cyc(0, 0, 0, 16'h0);
    tests++; if (udf[0] !== 1'b0) begin fails++; $display("FAIL underflow_pulse got %b exp 0", udf[0]); end
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 16'($urandom));
    cyc(0, 1, 0, 16'h5555);
    tests++; if (ovf[0] !== 1'b1 || ack[0] !== 1'b0 || cnt_a !== 4'd8) begin fails++; $display("FAIL overflow got ovf=%b ack=%b cnt=%0d exp 1 0 8", ovf[0], ack[0], cnt_a); end
    cyc(0, 0, 0, 16'h0);
    tests++; if (ovf[0] !== 1'b0) begin fails++; $display("FAIL overflow_pulse got %b exp 0", ovf[0]); end
  endtask

  task automatic test_simultaneous();
    cyc(0, 1, 1, 16'hBEEF);
    tests++; if (cnt_a !== 4'd7 || ovf[0] !== 1'b1 || ack[0] !== 1'b0) begin fails++; $display("FAIL simul_full got cnt=%0d ovf=%b ack=%b exp 7 1 0", cnt_a, ovf[0], ack[0]); end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'h0);
    cyc(0, 1, 1, 16'h1234);
    tests++; if (cnt_a !== 4'd4 || ack[0] !== 1'b1 || ovf[0] !== 1'b0) begin fails++; $display("FAIL simul_mid got cnt=%0d ack=%b ovf=%b exp 4 1 0", cnt_a, ack[0], ovf[0]); end
    tests++; if (dout[0] !== m_data(0)) begin fails++; $display("FAIL simul_mid_data got %h exp %h", dout[0], m_data(0)); end
    while (msize(0) > 0) begin
      cyc(0, 0, 1, 16'h0);
      if (data_valid(0)) begin
        tests++; if (dout[0] !== m_data(0)) begin fails++; $display("FAIL simul_order got %h exp %h", dout[0], m_data(0)); end
      end
    end
    cyc(0, 1, 1, 16'h7777);
    tests++; if (cnt_a !== 4'd1 || udf[0] !== 1'b1 || ack[0] !== 1'b1) begin fails++; $display("FAIL simul_empty got cnt=%0d udf=%b ack=%b exp 1 1 1", cnt_a, udf[0], ack[0]); end
    cyc(0, 0, 1, 16'h0);
`ifndef FIFO_FWFT_EN
    tests++; if (dout[0] !== 16'h7777) begin fails++; $display("FAIL simul_empty_data got %h exp 7777", dout[0]); end
`endif
  endtask

  task automatic test_thresholds();
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0, 16'(i));
      tests++; if (af[0] !== (i >= 6) || ae[0] !== (i <= 2)) begin fails++; $display("FAIL thr_up cnt=%0d got af=%b ae=%b exp %b %b", i, af[0], ae[0], i >= 6, i <= 2); end
    end
    for (int i = 7; i >= 0; i--) begin
      cyc(0, 0, 1, 16'h0);
      tests++; if (af[0] !== (i >= 6) || ae[0] !== (i <= 2)) begin fails++; $display("FAIL thr_down cnt=%0d got af=%b ae=%b exp %b %b", i, af[0], ae[0], i >= 6, i <= 2); end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 16'hC000 + 16'(i));
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 16'h0);
    tests++; if (m_dout[1] !== 16'hC002) begin fails++; $display("FAIL wrap_model got %h exp c002", m_dout[1]); end
    for (int i = 0; i < 20; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      cyc(1, 1, 0, v);
      if (data_valid(1)) begin
        tests++; if (dout[1] !== m_data(1)) begin fails++; $display("FAIL wrap_wdata[%0d] got %h exp %h", i, dout[1], m_data(1)); end
      end
      cyc(1, 0, 1, 16'h0);
      if (data_valid(1)) begin
        tests++; if (dout[1] !== m_data(1)) begin fails++; $display("FAIL wrap_rdata[%0d] got %h exp %h", i, dout[1], m_data(1)); end
      end
      tests++; if (empty[1] !== 1'b1) begin fails++; $display("FAIL wrap_empty[%0d] got %b exp 1", i, empty[1]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      int s, pw;
      bit w, r;
      s  = int'($urandom_range(0, 1));
      pw = (i < 500) ? 70 : (i < 1000) ? 30 : 50;
      w  = ($urandom_range(0, 99) < pw);
      r  = ($urandom_range(0, 99) < 100 - pw);
      cyc(s, w, r, 16'($urandom));
      tests++; if (obs_cnt(s) != msize(s)) begin fails++; $display("FAIL rnd_count[%0d] i=%0d got %0d exp %0d", s, i, obs_cnt(s), msize(s)); end
      tests++; if (full[s] !== (msize(s) == mdepth(s)) || empty[s] !== (msize(s) == 0)) begin fails++; $display("FAIL rnd_flags[%0d] i=%0d got full=%b empty=%b size=%0d", s, i, full[s], empty[s], msize(s)); end
      tests++; if (af[s] !== (msize(s) >= maf(s)) || ae[s] !== (msize(s) <= mae(s))) begin fails++; $display("FAIL rnd_almost[%0d] i=%0d got af=%b ae=%b size=%0d", s, i, af[s], ae[s], msize(s)); end
      tests++; if ({ack[s], ovf[s], udf[s]} !== {m_ack[s], m_ovf[s], m_udf[s]}) begin fails++; $display("FAIL rnd_pulses[%0d] i=%0d got %b exp %b", s, i, {ack[s], ovf[s], udf[s]}, {m_ack[s], m_ovf[s], m_udf[s]}); end
      if (data_valid(s)) begin
        tests++; if (dout[s] !== m_data(s)) begin fails++; $display("FAIL rnd_data[%0d] i=%0d got %h exp %h", s, i, dout[s], m_data(s)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    while (msize(0) > 0) cyc(0, 0, 1, 16'h0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 16'h3000 + 16'(i));
    tests++; if (cnt_a !== 4'd5) begin fails++; $display("FAIL rstmid_pre got %0d exp 5", cnt_a); end
    do_reset(1'b1);
    tests++; if (cnt_a !== 4'd0 || empty[0] !== 1'b1) begin fails++; $display("FAIL rstmid_count got cnt=%0d empty=%b exp 0 1", cnt_a, empty[0]); end
    tests++; if ({ack[0], ovf[0], udf[0]} !== 3'b000) begin fails++; $display("FAIL rstmid_pulses got %b exp 000", {ack[0], ovf[0], udf[0]}); end
    cyc(0, 1, 0, 16'h5A5A);
`ifdef FIFO_FWFT_EN
    tests++; if (dout[0] !== 16'h5A5A) begin fails++; $display("FAIL rstmid_data got %h exp 5a5a", dout[0]); end
`endif
    cyc(0, 0, 1, 16'h0);
`ifndef FIFO_FWFT_EN
    tests++; if (dout[0] !== 16'h5A5A) begin fails++; $display("FAIL rstmid_data got %h exp 5a5a", dout[0]); end
`endif
    tests++; if (empty[0] !== 1'b1) begin fails++; $display("FAIL rstmid_empty got %b exp 1", empty[0]); end
  endtask

  initial begin
    rst_n = 1'b0; we = '0; re = '0; din = '0;
    model_clear();
    @(posedge clk); #1;
    test_reset();
    test_fill_drain();
    test_over_under();
    test_simultaneous();
    test_thresholds();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
